attach_user_axis_stall_detect: RTL and testbench

Generates the per-stream blocking indications (`axis_block_sigs`) consumed by the attach_user HLS deadlock monitor. Watches the AXI-Stream handshake of each monitored port of the attach_user instance. Declares a channel blocked once it has stalled for a programmable number of consecutive cycles, and clears the indication as soon as the stall ends. Sits beside the attach_user instance, between its stream ports and the deadlock monitor input.

---
 rtl/attach_user_deadlock_pkg.sv | 27 ++
 rtl/attach_user_axis_stall_detect_if.sv | 19 +
 rtl/attach_user_axis_stall_chan.sv | 100 ++++++++++
 rtl/attach_user_axis_stall_detect.sv | 105 ++++++++++
 tb/tb_attach_user_axis_stall_detect.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/attach_user_deadlock_pkg.sv
// ----------------------------------------------------------------------------
// attach_user_deadlock_pkg
// Shared definitions for the attach_user deadlock-monitor front end:
//   - stall_state_e : per-channel stall FSM states
//   - DEF_CNT_W     : default stall counter width
//   - sat_inc()     : increment that sticks at all-ones for a given width
// Optional feature macro used by the importing modules:
//   ATTACH_USER_STALL_STATS_EN
// ----------------------------------------------------------------------------
package attach_user_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_BLOCKED = 2'd2
  } stall_state_e;

  localparam int DEF_CNT_W = 16;

  // Saturating increment of the low w bits of v (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/attach_user_axis_stall_detect_if.sv
// ----------------------------------------------------------------------------
// attach_user_axis_stall_detect_if
// Bundle of the per-channel AXI-Stream handshake wires being observed.
//   ch_tvalid [NUM_CH] : TVALID of each monitored stream
//   ch_tready [NUM_CH] : TREADY of each monitored stream
// Modports:
//   master : whoever drives the handshake (stream endpoints / bench)
//   slave  : observe-only consumer (the stall detector)
// Related feature macro (not used here): ATTACH_USER_STALL_STATS_EN
// ----------------------------------------------------------------------------
interface attach_user_axis_stall_detect_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0] ch_tvalid;
  logic [NUM_CH-1:0] ch_tready;

  modport master (output ch_tvalid, output ch_tready);
  modport slave  (input  ch_tvalid, input  ch_tready);
endinterface

// File: rtl/attach_user_axis_stall_chan.sv
// ----------------------------------------------------------------------------
// attach_user_axis_stall_chan
// One channel of the stall detector: IDLE/COUNT/BLOCKED FSM with a
// saturating run-length counter.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   enable         : low forces IDLE, counter 0, flag 0
//   stall          : qualified stall condition for this channel
//   thresh_eff     : effective threshold (already forced to >= 1)
//   blk_nxt        : value the block flag takes at the next edge
//   block          : registered block flag
//   stall_max      : longest stall run seen (ATTACH_USER_STALL_STATS_EN only)
// ----------------------------------------------------------------------------
module attach_user_axis_stall_chan
  import attach_user_deadlock_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             stall,
  input  logic [CNT_W-1:0] thresh_eff,
  output logic             blk_nxt,
  output logic             block
`ifdef ATTACH_USER_STALL_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_max
`endif
);

  stall_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // cnt is 0 in IDLE, so cnt_inc is also the length of the run including
  // the cycle being sampled, in every state.
  assign cnt_inc = CNT_W'(sat_inc(32'(cnt), CNT_W));

  // Once BLOCKED, the flag holds for the whole run even if the threshold
  // is raised underneath it.
  assign blk_nxt = enable & stall & ((state == ST_BLOCKED) | (cnt_inc >= thresh_eff));

  // stage 1: FSM state, counter and flag registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      block <= 1'b0;
    end else if (!enable) begin
      state <= ST_IDLE;
      cnt   <= '0;
      block <= 1'b0;
    end else begin
      block <= blk_nxt;
      case (state)
        ST_IDLE: begin
          if (stall) begin
            cnt   <= cnt_inc;
            state <= blk_nxt ? ST_BLOCKED : ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (stall) begin
            cnt <= cnt_inc;
            if (blk_nxt) state <= ST_BLOCKED;
          end else begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        ST_BLOCKED: begin
          if (stall) begin
            cnt <= cnt_inc;
          end else begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ATTACH_USER_STALL_STATS_EN
  // Tracking the live run length covers both "run ends" and "run grows
  // past the record" in one compare.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_max <= '0;
    end else if (enable && stall && (cnt_inc > stall_max)) begin
      stall_max <= cnt_inc;
    end
  end
`endif

endmodule

// File: rtl/attach_user_axis_stall_detect.sv
// ----------------------------------------------------------------------------
// attach_user_axis_stall_detect
// Observe-only AXI-Stream stall detector producing the per-stream blocking
// indications for the attach_user deadlock monitor.
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset
//   enable           : detection enable; low clears all channels
//   stall_thresh     : consecutive stalled cycles before blocking (0 acts as 1)
//   inst_idle        : instance idle; masks input-side starvation
//   axis (slave)     : per-channel ch_tvalid / ch_tready being watched
//   axis_block_sigs  : registered per-channel block flags
//   any_block        : registered OR of the flags
//   stall_max        : per-channel longest stall run  (stats build only)
//   first_block_ch   : {valid, lowest channel that blocked first} (stats only)
// Optional feature macro: ATTACH_USER_STALL_STATS_EN (requires NUM_CH >= 2).
// ----------------------------------------------------------------------------
module attach_user_axis_stall_detect
  import attach_user_deadlock_pkg::*;
#(
  parameter int              NUM_CH    = 2,
  parameter int              CNT_W     = DEF_CNT_W,
  parameter logic [NUM_CH-1:0] CH_IS_OUT = 2'b10
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [CNT_W-1:0]            stall_thresh,
  input  logic                        inst_idle,
  attach_user_axis_stall_detect_if.slave axis,
  output logic [NUM_CH-1:0]           axis_block_sigs,
  output logic                        any_block
`ifdef ATTACH_USER_STALL_STATS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0]     stall_max,
  output logic [$clog2(NUM_CH):0]     first_block_ch
`endif
);

  logic [CNT_W-1:0]  thresh_eff;
  logic [NUM_CH-1:0] stall_p0;
  logic [NUM_CH-1:0] blk_p0;

  assign thresh_eff = (stall_thresh == '0) ? CNT_W'(1) : stall_thresh;

  // stage 0: stall qualification per direction (completed transfers never stall)
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign stall_p0[i] = CH_IS_OUT[i]
                       ? (axis.ch_tvalid[i] & ~axis.ch_tready[i])
                       : (axis.ch_tready[i] & ~axis.ch_tvalid[i] & ~inst_idle);

    attach_user_axis_stall_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clock      (clock),
      .reset_n    (reset_n),
      .enable     (enable),
      .stall      (stall_p0[i]),
      .thresh_eff (thresh_eff),
      .blk_nxt    (blk_p0[i]),
      .block      (axis_block_sigs[i])
`ifdef ATTACH_USER_STALL_STATS_EN
      ,
      .stall_max  (stall_max[i*CNT_W +: CNT_W])
`endif
    );
  end

  // stage 1: OR reduction registered at the same edge as the flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) any_block <= 1'b0;
    else          any_block <= |blk_p0;
  end

`ifdef ATTACH_USER_STALL_STATS_EN
  localparam int IDX_W = $clog2(NUM_CH);

  logic             fb_vld;
  logic [IDX_W-1:0] fb_idx;
  logic [IDX_W-1:0] fb_new_idx;

  // Lowest index wins when several channels block on the same edge.
  always_comb begin
    fb_new_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (blk_p0[i]) fb_new_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fb_vld <= 1'b0;
      fb_idx <= '0;
    end else if (!enable) begin
      fb_vld <= 1'b0;
      fb_idx <= '0;
    end else if (!fb_vld && (|blk_p0)) begin
      fb_vld <= 1'b1;
      fb_idx <= fb_new_idx;
    end
  end

  assign first_block_ch = {fb_vld, fb_idx};
`endif

endmodule

// File: tb/tb_attach_user_axis_stall_detect.sv
// ----------------------------------------------------------------------------
// tb_attach_user_axis_stall_detect
// Directed bench: channel 0 is an output stream, channel 1 an input stream,
// CNT_W = 4. Each stimulus cycle queues the hand-computed flag pattern
// expected after the following edge; a monitor pops and compares on every
// falling edge. Stats checks (ATTACH_USER_STALL_STATS_EN) are direct.
// ----------------------------------------------------------------------------
module tb_attach_user_axis_stall_detect;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic [CNT_W-1:0] stall_thresh = '0;
  logic             inst_idle = 1'b0;
  logic [1:0]       axis_block_sigs;
  logic             any_block;
`ifdef ATTACH_USER_STALL_STATS_EN
  logic [NUM_CH*CNT_W-1:0] stall_max;
  logic [1:0]              first_block_ch;
`endif

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  attach_user_axis_stall_detect_if #(.NUM_CH(NUM_CH)) axis ();

  attach_user_axis_stall_detect #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .CH_IS_OUT (2'b01)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable          (enable),
    .stall_thresh    (stall_thresh),
    .inst_idle       (inst_idle),
    .axis            (axis),
    .axis_block_sigs (axis_block_sigs),
    .any_block       (any_block)
`ifdef ATTACH_USER_STALL_STATS_EN
    ,
    .stall_max       (stall_max),
    .first_block_ch  (first_block_ch)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One stimulus cycle: drive after the falling edge, queue the flags
  // expected after the next rising edge.
  task automatic cyc(input logic en, input logic [CNT_W-1:0] thr, input logic idl,
                     input logic [1:0] tv, input logic [1:0] tr, input logic [1:0] e);
    @(negedge clock);
    #1;
    enable          = en;
    stall_thresh    = thr;
    inst_idle       = idl;
    axis.ch_tvalid  = tv;
    axis.ch_tready  = tr;
    exp_q.push_back(e);
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      chk("axis_block_sigs", 32'(axis_block_sigs), 32'(e));
      chk("any_block", 32'(any_block), 32'(|e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    axis.ch_tvalid = '0;
    axis.ch_tready = '0;

    // Held in reset with both channels stalling: flags stay low
    cyc(1'b1, 4'd1, 1'b0, 2'b01, 2'b10, 2'b00);
    cyc(1'b1, 4'd1, 1'b0, 2'b01, 2'b10, 2'b00);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Output channel 0, threshold 4
    for (int k = 0; k < 4; k++) cyc(1'b1, 4'd4, 1'b1, 2'b01, 2'b00, (k == 3) ? 2'b01 : 2'b00);
`ifdef ATTACH_USER_STALL_STATS_EN
    @(posedge clock); #1;
    chk("first_block_ch_ch0", 32'(first_block_ch), 32'h2);
`endif
    cyc(1'b1, 4'd4, 1'b1, 2'b01, 2'b01, 2'b00);  // transfer ends the stall
    cyc(1'b1, 4'd4, 1'b1, 2'b00, 2'b00, 2'b00);

    // Input channel 1, threshold 3: masked while idle, then starved
    for (int k = 0; k < 10; k++) cyc(1'b1, 4'd3, 1'b1, 2'b00, 2'b10, 2'b00);
    cyc(1'b1, 4'd3, 1'b0, 2'b00, 2'b10, 2'b00);
    cyc(1'b1, 4'd3, 1'b0, 2'b00, 2'b10, 2'b00);
    cyc(1'b1, 4'd3, 1'b0, 2'b00, 2'b10, 2'b10);
    cyc(1'b1, 4'd3, 1'b0, 2'b00, 2'b10, 2'b10);
    cyc(1'b1, 4'd3, 1'b0, 2'b10, 2'b10, 2'b00);  // transfer

    // Threshold 0 and 1 both block after a single stalled cycle
    cyc(1'b1, 4'd0, 1'b1, 2'b01, 2'b00, 2'b01);
    cyc(1'b1, 4'd0, 1'b1, 2'b00, 2'b00, 2'b00);
    cyc(1'b1, 4'd1, 1'b1, 2'b01, 2'b00, 2'b01);
    cyc(1'b1, 4'd1, 1'b1, 2'b00, 2'b00, 2'b00);

    // Long stall, threshold 5: counter saturates, flag holds
    for (int k = 0; k < 40; k++) cyc(1'b1, 4'd5, 1'b1, 2'b01, 2'b00, (k >= 4) ? 2'b01 : 2'b00);
    cyc(1'b1, 4'd5, 1'b1, 2'b00, 2'b00, 2'b00);
`ifdef ATTACH_USER_STALL_STATS_EN
    @(posedge clock); #1;
    chk("stall_max_sat", 32'(stall_max), 32'h4F);
`endif

    // Asynchronous reset while BLOCKED
    cyc(1'b1, 4'd2, 1'b1, 2'b01, 2'b00, 2'b00);
    cyc(1'b1, 4'd2, 1'b1, 2'b01, 2'b00, 2'b01);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_flags", 32'(axis_block_sigs), 32'h0);
    chk("async_rst_any", 32'(any_block), 32'h0);
`ifdef ATTACH_USER_STALL_STATS_EN
    chk("async_rst_stall_max", 32'(stall_max), 32'h0);
    chk("async_rst_first_block", 32'(first_block_ch), 32'h0);
`endif
    cyc(1'b1, 4'd2, 1'b1, 2'b00, 2'b00, 2'b00);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // enable low while counting restarts the run from IDLE
    cyc(1'b1, 4'd3, 1'b1, 2'b01, 2'b00, 2'b00);
    cyc(1'b1, 4'd3, 1'b1, 2'b01, 2'b00, 2'b00);
    cyc(1'b0, 4'd3, 1'b1, 2'b01, 2'b00, 2'b00);
    cyc(1'b1, 4'd3, 1'b1, 2'b01, 2'b00, 2'b00);
    cyc(1'b1, 4'd3, 1'b1, 2'b01, 2'b00, 2'b00);
    cyc(1'b1, 4'd3, 1'b1, 2'b01, 2'b00, 2'b01);
    cyc(1'b1, 4'd3, 1'b1, 2'b00, 2'b00, 2'b00);

    // Simultaneous block on both channels, threshold 2
    cyc(1'b0, 4'd2, 1'b0, 2'b00, 2'b00, 2'b00);
    cyc(1'b1, 4'd2, 1'b0, 2'b01, 2'b10, 2'b00);
    cyc(1'b1, 4'd2, 1'b0, 2'b01, 2'b10, 2'b11);
`ifdef ATTACH_USER_STALL_STATS_EN
    @(posedge clock); #1;
    chk("first_block_ch_simul", 32'(first_block_ch), 32'h2);
`endif
    cyc(1'b1, 4'd2, 1'b0, 2'b00, 2'b00, 2'b00);

    @(negedge clock);
    @(negedge clock);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
